rc4_sbox_sched: RTL and testbench
=================================

# rc4_sbox_sched

Sequencer for the shared 256x8 S-box RAM (`ram`, ports 1/2/3) used by the RC4 keystream path. It owns every RAM port and runs three phases per request: identity fill, key scheduling (KSA), and keystream generation (PRGA). PRGA bytes go out through a valid/ready handshake. It sits between the host configuration logic and the `ram` instance and replaces ad-hoc port sharing with one deterministic schedule.

## Interface
- `KEY_BYTES`, 4, maximum key length in bytes; `key` is 8*KEY_BYTES wide.
- `LEN_W`, 16, width of the keystream byte count.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request pulse; sampled only in IDLE
- `key`  in  8*KEY_BYTES  key; byte n = `key[8n+7:8n]`
- `key_length`  in  8  key length in bytes, legal range 1..KEY_BYTES
- `ks_len`  in  LEN_W  number of keystream bytes to produce
- `ks_data`  out  8  keystream byte
- `ks_valid`  out  1  `ks_data` valid
- `ks_ready`  in  1  consumer accepts `ks_data`
- `busy`  out  1  high from accepted start until return to IDLE
- `done`  out  1  one-cycle pulse when the request completes
- `cfg_err`  out  1  one-cycle pulse when a start is rejected
- `raddr_1`  out  8  RAM port 1 read address
- `rdata_1`  in  8  RAM port 1 read data
- `wen_2`, `waddr_2`, `wdata_2`  out  1/8/8  RAM port 2 write
- `wen_3`, `addr_3`, `wdata_3`  out  1/8/8  RAM port 3 read/write
- `rdata_3`  in  8  RAM port 3 read data

## Operation
- RAM contract:
  - Synchronous reads: an address present at edge N gives data after edge N.
  - Writes commit at the edge.
  - A read addressed the cycle after a write returns the new data.
- Start handling:
  - In IDLE, a `start` with `key_length` in 1..KEY_BYTES latches `key`, `key_length` and `ks_len`, then enters FILL.
  - Any other `key_length` pulses `cfg_err`, and the block stays in IDLE.
  - `start` outside IDLE is ignored.
- FILL, 256 cycles: `wen_2`=1, `waddr_2`=`wdata_2`=idx, idx counts 0..255.
- KSA, 4 cycles per i, i = 0..255, j starts at 0:
  - K0: `raddr_1`=i.
  - K1: Si<=`rdata_1`; j<=j+`rdata_1`+key byte[kidx]. kidx wraps to 0 after `key_length`-1, so no divider is needed.
  - K2: `addr_3`=j.
  - K3: Sj<=`rdata_3`. Write port 2 (i, Sj) and port 3 (j, Si). i<=i+1. After i=255, go to PRGA with i=1, j=0.
- PRGA, per byte:
  - P0: `raddr_1`=i.
  - P1: Si<=`rdata_1`; j<=j+`rdata_1`.
  - P2: `addr_3`=j.
  - P3: Sj<=`rdata_3`; swap writes as in K3; t<=Si+Sj.
  - P4: `raddr_1`=t.
  - P5: `ks_data`<=`rdata_1`, `ks_valid`<=1.
  - OUT: hold until `ks_ready`. On the handshake edge, `ks_valid`<=0, i<=i+1, count<=count+1. If count reached `ks_len`, pulse `done` and go to IDLE; otherwise go to P0.
- Arithmetic and ordering:
  - All index and sum arithmetic is 8-bit modulo 256. i and t wrap 255->0.
  - When i==j, both ports write the same address with identical data; this is legal.
  - The byte count is LEN_W bits.
- `ks_len`=0: skip PRGA and pulse `done` on leaving the last K3.
- `done` and `busy`: `busy` drops on the same edge that raises `done`.
- RAM port enables are 0 in every state not listed above. Unused addresses and data are 0.
- Reset mid-operation:
  - All state returns to IDLE immediately.
  - RAM contents are treated as undefined, and the next request re-runs FILL.
  - No `done` pulse is produced.

## Timing
- Reset values: `ks_data`=0, `ks_valid`=0, `busy`=0, `done`=0, `cfg_err`=0, all `wen_*`=0, all addresses and write data 0. Internal i, j, kidx, count are 0.
- Edge E0 samples `start`.
- FILL occupies E1..E256. KSA occupies E257..E1280.
- First `ks_valid` is high after E1286.
- With `ks_ready` held at 1, bytes arrive every 7 cycles.
- `cfg_err` is high for exactly the cycle after E0.
- With `ks_len`=0, `done` is high after E1281 and `busy` is low from E1281.
- `ks_data` is stable while `ks_valid`=1 and `ks_ready`=0.

## Test plan
- "Key": `key`=32'h0079654B, `key_length`=3, `ks_len`=10, `ks_ready`=1 -> bytes EB 9F 77 81 B7 34 CA 72 A7 19. First valid after E1286, then every 7 cycles, `done` once.
- "Wiki": `key`=32'h696B6957, `key_length`=4, `ks_len`=5 -> 60 44 DB 6D 41.
- Backpressure on "Key": hold `ks_ready`=0 for 10 cycles on byte 2 -> `ks_data`=9F held stable with `ks_valid`=1. The remaining sequence is unchanged.
- Rejected starts: `key_length`=0, then 5 -> one-cycle `cfg_err` each, `busy` stays 0, no RAM writes.
- Reset and retry: assert `rst` during KSA (cycle ~600), then restart "Key" -> outputs are the reset values, and the rerun yields EB 9F 77 81.
- Zero length: `ks_len`=0 -> `done` after E1281 with no `ks_valid`. A `start` pulsed during the busy period is ignored.

Source files
------------

// File: rtl/rc4_sbox_sched.sv
// RC4 S-box sequencer: owns the 256x8 RAM ports and runs identity fill, key scheduling and
// keystream generation per request, emitting keystream bytes through a valid/ready handshake.
module rc4_sbox_sched #(
  parameter int KEY_BYTES = 4,
  parameter int LEN_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [7:0]             key_length,
  input  logic [LEN_W-1:0]       ks_len,
  output logic [7:0]             ks_data,
  output logic                   ks_valid,
  input  logic                   ks_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [7:0]             raddr_1,
  input  logic [7:0]             rdata_1,
  output logic                   wen_2,
  output logic [7:0]             waddr_2,
  output logic [7:0]             wdata_2,
  output logic                   wen_3,
  output logic [7:0]             addr_3,
  output logic [7:0]             wdata_3,
  input  logic [7:0]             rdata_3
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_K0, S_K1, S_K2, S_K3,
    S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_OUT, S_FIN
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d, j_q, j_d, si_q, si_d;
  logic [KW-1:0]          kidx_q, kidx_d, klast_q, klast_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             ks_data_q, ks_data_d, raddr_1_q, raddr_1_d;
  logic [7:0]             waddr_2_q, waddr_2_d, wdata_2_q, wdata_2_d;
  logic [7:0]             addr_3_q, addr_3_d, wdata_3_q, wdata_3_d;
  logic                   ks_valid_q, ks_valid_d, busy_q, busy_d, done_q, done_d;
  logic                   cfg_err_q, cfg_err_d, wen_2_q, wen_2_d, wen_3_q, wen_3_d;
  logic [7:0]             kbyte, j_ksa, j_prga;

  assign kbyte   = key_q[kidx_q*8 +: 8];
  assign j_ksa   = j_q + rdata_1 + kbyte;
  assign j_prga  = j_q + rdata_1;
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    kidx_d     = kidx_q;
    klast_d    = klast_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    key_d      = key_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    // RAM controls are rebuilt every cycle so any state not driving them leaves them at 0.
    raddr_1_d  = 8'd0;
    wen_2_d    = 1'b0;
    waddr_2_d  = 8'd0;
    wdata_2_d  = 8'd0;
    wen_3_d    = 1'b0;
    addr_3_d   = 8'd0;
    wdata_3_d  = 8'd0;
    case (state_q)
      S_IDLE: if (start) begin
        if (key_length != 8'd0 && key_length <= 8'(KEY_BYTES)) begin
          key_d   = key;
          klast_d = KW'(key_length - 8'd1);
          len_d   = ks_len;
          busy_d  = 1'b1;
          i_d     = 8'd0;
          j_d     = 8'd0;
          kidx_d  = '0;
          cnt_d   = '0;
          wen_2_d = 1'b1;
          state_d = S_FILL;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
      S_FILL: if (i_q == 8'hFF) begin
        i_d     = 8'd0;
        state_d = S_K0;
      end else begin
        i_d       = i_q + 8'd1;
        wen_2_d   = 1'b1;
        waddr_2_d = i_q + 8'd1;
        wdata_2_d = i_q + 8'd1;
      end
      S_K0: state_d = S_K1;
      S_K1: begin
        si_d     = rdata_1;
        j_d      = j_ksa;
        addr_3_d = j_ksa;
        kidx_d   = (kidx_q == klast_q) ? '0 : kidx_q + KW'(1);
        state_d  = S_K2;
      end
      // Swap writes are issued in the following cycle; Sj arrives combinationally from rdata_3.
      S_K2, S_P2: begin
        wen_2_d   = 1'b1;
        waddr_2_d = i_q;
        wen_3_d   = 1'b1;
        addr_3_d  = j_q;
        wdata_3_d = si_q;
        state_d   = (state_q == S_K2) ? S_K3 : S_P3;
      end
      S_K3: begin
        i_d = i_q + 8'd1;
        if (i_q != 8'hFF) begin
          raddr_1_d = i_q + 8'd1;
          state_d   = S_K0;
        end else if (len_q == '0) begin
          state_d = S_FIN;
        end else begin
          i_d       = 8'd1;
          j_d       = 8'd0;
          raddr_1_d = 8'd1;
          state_d   = S_P0;
        end
      end
      S_P0: state_d = S_P1;
      S_P1: begin
        si_d     = rdata_1;
        j_d      = j_prga;
        addr_3_d = j_prga;
        state_d  = S_P2;
      end
      S_P3: begin
        raddr_1_d = si_q + rdata_3;
        state_d   = S_P4;
      end
      S_P4: state_d = S_P5;
      S_P5: begin
        ks_data_d  = rdata_1;
        ks_valid_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: if (ks_ready) begin
        ks_valid_d = 1'b0;
        i_d        = i_q + 8'd1;
        cnt_d      = cnt_inc;
        if (cnt_inc == len_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          raddr_1_d = i_q + 8'd1;
          state_d   = S_P0;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      si_q       <= 8'd0;
      kidx_q     <= '0;
      klast_q    <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      key_q      <= '0;
      ks_data_q  <= 8'd0;
      ks_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      raddr_1_q  <= 8'd0;
      wen_2_q    <= 1'b0;
      waddr_2_q  <= 8'd0;
      wdata_2_q  <= 8'd0;
      wen_3_q    <= 1'b0;
      addr_3_q   <= 8'd0;
      wdata_3_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      kidx_q     <= kidx_d;
      klast_q    <= klast_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      key_q      <= key_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      raddr_1_q  <= raddr_1_d;
      wen_2_q    <= wen_2_d;
      waddr_2_q  <= waddr_2_d;
      wdata_2_q  <= wdata_2_d;
      wen_3_q    <= wen_3_d;
      addr_3_q   <= addr_3_d;
      wdata_3_q  <= wdata_3_d;
    end
  end

  assign ks_data  = ks_data_q;
  assign ks_valid = ks_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
  assign raddr_1  = raddr_1_q;
  assign wen_2    = wen_2_q;
  assign waddr_2  = waddr_2_q;
  assign wdata_2  = (state_q == S_K3 || state_q == S_P3) ? rdata_3 : wdata_2_q;
  assign wen_3    = wen_3_q;
  assign addr_3   = addr_3_q;
  assign wdata_3  = wdata_3_q;

endmodule

// File: tb/tb_rc4_sbox_sched.sv
// Bench for rc4_sbox_sched: behavioural S-box RAM, known RC4 vectors plus a software RC4 model.
module tb_rc4_sbox_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] key = 32'd0;
  logic [7:0]  key_length = 8'd0;
  logic [15:0] ks_len = 16'd0;
  logic        ks_ready = 1'b0;
  logic [7:0]  ks_data, raddr_1, rdata_1, waddr_2, wdata_2, addr_3, wdata_3, rdata_3;
  logic        ks_valid, busy, done, cfg_err, wen_2, wen_3;

  rc4_sbox_sched #(.KEY_BYTES(4), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .key_length(key_length), .ks_len(ks_len),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy), .done(done),
    .cfg_err(cfg_err), .raddr_1(raddr_1), .rdata_1(rdata_1), .wen_2(wen_2), .waddr_2(waddr_2),
    .wdata_2(wdata_2), .wen_3(wen_3), .addr_3(addr_3), .wdata_3(wdata_3), .rdata_3(rdata_3)
  );

  always #5 clk = ~clk;

  // RAM contents become garbage whenever reset is held, so every request must refill.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'($urandom);
    end else begin
      if (wen_2) mem[waddr_2] <= wdata_2;
      if (wen_3) mem[addr_3] <= wdata_3;
    end
    rdata_1 <= mem[raddr_1];
    rdata_3 <= mem[addr_3];
  end

  int cyc = 0;
  int wr_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wen_2 || wen_3) wr_cnt <= wr_cnt + 1;
  end

  logic [53:0] outs;
  assign outs = {ks_data, ks_valid, busy, done, cfg_err, raddr_1, wen_2, waddr_2, wdata_2,
                 wen_3, addr_3, wdata_3};

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  function automatic void rc4_model(input logic [31:0] k, input int kl, input int n);
    int s[256];
    int i, j, t;
    logic [7:0] kb;
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      kb = k[8*(a % kl) +: 8];
      j = (j + s[a] + int'(kb)) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int c = 0; c < n; c++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      sb.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endfunction

  task automatic start_req(input logic [31:0] k, input logic [7:0] kl, input logic [15:0] len,
                           output int e0);
    @(negedge clk);
    key = k; key_length = kl; ks_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs !== 54'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_key();
    int e0, last, n;
    bit got_done;
    logic [7:0] exp;
    logic [7:0] tbl [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    sb.delete();
    foreach (tbl[q]) sb.push_back(tbl[q]);
    ks_ready = 1'b1;
    start_req(32'h0079654B, 8'd3, 16'd10, e0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL key_busy: got %b expected 1", busy); end
    n = 0; last = 0; got_done = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (done) begin
        n_cmp++;
        if (cyc - last != 1 || busy !== 1'b0 || sb.size() != 0) begin
          n_bad++;
          $display("FAIL key_done: gap %0d busy %b left %0d expected gap 1 busy 0 left 0",
                   cyc - last, busy, sb.size());
        end
        got_done = 1;
        break;
      end
      if (ks_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL key_extra: got byte %02h expected none", ks_data);
        end else begin
          exp = sb.pop_front();
          if (ks_data !== exp) begin
            n_bad++; $display("FAIL key_byte%0d: got %02h expected %02h", n, ks_data, exp);
          end
        end
        n_cmp++;
        if ((n == 0) ? (cyc - e0 != 1286) : (cyc - last != 7)) begin
          n_bad++;
          $display("FAIL key_timing%0d: got %0d expected %0d", n,
                   (n == 0) ? cyc - e0 : cyc - last, (n == 0) ? 1286 : 7);
        end
        last = cyc; n++;
      end
    end
    n_cmp++;
    if (!got_done) begin n_bad++; $display("FAIL key_timeout: got no done expected done"); end
    n_cmp++;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) got_done = 0;
    end
    if (!got_done) begin n_bad++; $display("FAIL key_after: got done/busy expected idle"); end
  endtask

  task automatic test_wiki();
    int e0, n;
    bit got_done;
    logic [7:0] exp;
    logic [7:0] tbl [5] = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};
    sb.delete();
    foreach (tbl[q]) sb.push_back(tbl[q]);
    ks_ready = 1'b1;
    start_req(32'h696B6957, 8'd4, 16'd5, e0);
    n = 0; got_done = 0;
    for (int c = 0; c < 2500 && !got_done; c++) begin
      @(negedge clk);
      ks_ready = 1'($urandom_range(0, 1));
      if (done) got_done = 1;
      if (ks_valid && ks_ready) begin
        n_cmp++;
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        if (ks_data !== exp) begin
          n_bad++; $display("FAIL wiki_byte%0d: got %02h expected %02h", n, ks_data, exp);
        end
        n++;
      end
    end
    n_cmp++;
    if (!got_done || n != 5) begin
      n_bad++; $display("FAIL wiki_count: got %0d bytes done %b expected 5 bytes done 1", n, got_done);
    end
  endtask

  task automatic test_backpressure();
    int e0, n;
    bit got_done, held, stable;
    logic [7:0] exp;
    logic [7:0] tbl [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    sb.delete();
    foreach (tbl[q]) sb.push_back(tbl[q]);
    ks_ready = 1'b1;
    start_req(32'h0079654B, 8'd3, 16'd10, e0);
    n = 0; got_done = 0; held = 0;
    for (int c = 0; c < 1600 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
      if (ks_valid) begin
        if (n == 1 && !held) begin
          ks_ready = 1'b0; held = 1; stable = 1;
          repeat (10) begin
            @(negedge clk);
            if (!(ks_valid === 1'b1 && ks_data === 8'h9F)) stable = 0;
          end
          n_cmp++;
          if (!stable) begin
            n_bad++; $display("FAIL bp_hold: got valid %b data %02h expected 1 9F", ks_valid, ks_data);
          end
          ks_ready = 1'b1;
        end
        n_cmp++;
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        if (ks_data !== exp) begin
          n_bad++; $display("FAIL bp_byte%0d: got %02h expected %02h", n, ks_data, exp);
        end
        n++;
      end
    end
    n_cmp++;
    if (!got_done || n != 10) begin
      n_bad++; $display("FAIL bp_count: got %0d bytes done %b expected 10 bytes done 1", n, got_done);
    end
  endtask

  task automatic test_model_short_key();
    int e0, n;
    bit got_done;
    logic [7:0] exp;
    sb.delete();
    rc4_model(32'hA5C3E701, 1, 6);
    start_req(32'hA5C3E701, 8'd1, 16'd6, e0);
    n = 0; got_done = 0;
    for (int c = 0; c < 2500 && !got_done; c++) begin
      @(negedge clk);
      ks_ready = 1'($urandom_range(0, 1));
      if (done) got_done = 1;
      if (ks_valid && ks_ready) begin
        n_cmp++;
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        if (ks_data !== exp) begin
          n_bad++; $display("FAIL k1_byte%0d: got %02h expected %02h", n, ks_data, exp);
        end
        n++;
      end
    end
    n_cmp++;
    if (!got_done || n != 6) begin
      n_bad++; $display("FAIL k1_count: got %0d bytes done %b expected 6 bytes done 1", n, got_done);
    end
  endtask

  task automatic test_cfg_err();
    int e0, w0;
    logic [7:0] bad_len [2] = '{8'd0, 8'd5};
    foreach (bad_len[q]) begin
      w0 = wr_cnt;
      start_req(32'h0079654B, bad_len[q], 16'd4, e0);
      n_cmp++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        n_bad++; $display("FAIL cfg_pulse_len%0d: got err %b busy %b expected 1 0", bad_len[q], cfg_err, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL cfg_clear_len%0d: got err %b busy %b expected 0 0", bad_len[q], cfg_err, busy);
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (wr_cnt != w0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL cfg_nowrite_len%0d: got %0d writes expected 0", bad_len[q], wr_cnt - w0);
      end
    end
  endtask

  task automatic test_reset_retry();
    int e0, n;
    bit got_done, saw_done;
    logic [7:0] exp;
    ks_ready = 1'b1;
    start_req(32'h0079654B, 8'd3, 16'd10, e0);
    repeat (600) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 54'd0) begin n_bad++; $display("FAIL rst_mid: got %h expected 0", outs); end
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (done || busy) saw_done = 1; end
    n_cmp++;
    if (saw_done) begin n_bad++; $display("FAIL rst_quiet: got done/busy expected none"); end
    sb.delete();
    rc4_model(32'h0079654B, 3, 4);
    start_req(32'h0079654B, 8'd3, 16'd4, e0);
    n = 0; got_done = 0;
    for (int c = 0; c < 1500 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
      if (ks_valid) begin
        n_cmp++;
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        if (ks_data !== exp) begin
          n_bad++; $display("FAIL retry_byte%0d: got %02h expected %02h", n, ks_data, exp);
        end
        n++;
      end
    end
    n_cmp++;
    if (!got_done || n != 4) begin
      n_bad++; $display("FAIL retry_count: got %0d bytes done %b expected 4 bytes done 1", n, got_done);
    end
  endtask

  task automatic test_zero_len();
    int e0, done_at;
    bit saw_valid, busy_pre;
    start_req(32'h0079654B, 8'd3, 16'd0, e0);
    done_at = -1; saw_valid = 0; busy_pre = 0;
    for (int c = 0; c < 1400 && done_at < 0; c++) begin
      @(negedge clk);
      start = (c == 300);
      if (ks_valid) saw_valid = 1;
      if (cyc - e0 == 1280) busy_pre = busy;
      if (done) begin
        done_at = cyc - e0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL zl_busy: got %b expected 0", busy); end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (done_at != 1281) begin n_bad++; $display("FAIL zl_done: got %0d expected 1281", done_at); end
    n_cmp++;
    if (saw_valid || !busy_pre) begin
      n_bad++; $display("FAIL zl_flags: got valid %b busy_pre %b expected 0 1", saw_valid, busy_pre);
    end
    repeat (20) begin @(negedge clk); if (busy || done) saw_valid = 1; end
    n_cmp++;
    if (saw_valid) begin n_bad++; $display("FAIL zl_ignored_start: got activity expected idle"); end
  endtask

  initial begin
    test_reset();
    test_key();
    test_wiki();
    test_backpressure();
    test_model_short_key();
    test_cfg_err();
    test_reset_retry();
    test_zero_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
